// File: rtl/twiddle_sequencer_if.sv
// Twiddle stream bus: registered W with valid/ready flow control plus its
// stage/butterfly position and an end-of-frame marker.
interface twiddle_sequencer_if #(
    parameter int DATA_W = 16
);
    logic                     w_valid;
    logic                     w_ready;
    logic signed [DATA_W-1:0] w_re;
    logic signed [DATA_W-1:0] w_im;
    logic [1:0]               stage;
    logic [2:0]               bfly;
    logic                     last;

    modport master (
        output w_valid, w_re, w_im, stage, bfly, last,
        input  w_ready
    );

    modport slave (
        input  w_valid, w_re, w_im, stage, bfly, last,
        output w_ready
    );
endinterface

// File: rtl/twiddle_sequencer.sv
// Streams the 32 twiddles of a 16-point radix-2 DIT FFT frame, stage-major.
// Optional macro TWIDDLE_INVERSE_EN adds the `inverse` input for conjugate (IFFT) twiddles.
module twiddle_sequencer #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
`ifdef TWIDDLE_INVERSE_EN
    input  logic               inverse,
`endif
    twiddle_sequencer_if.master w,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Quarter-wave magnitudes, rounded once at elaboration for the chosen FRAC_W.
    localparam int  K0    = 1 << FRAC_W;
    localparam real SCALE = real'(K0);
    localparam int  K1    = int'(0.92387953251128674 * SCALE);
    localparam int  K2    = int'(0.70710678118654752 * SCALE);
    localparam int  K3    = int'(0.38268343236508977 * SCALE);

    function automatic logic signed [DATA_W-1:0] cos_lut(input logic [2:0] e);
        case (e)
            3'd0:    return DATA_W'(K0);
            3'd1:    return DATA_W'(K1);
            3'd2:    return DATA_W'(K2);
            3'd3:    return DATA_W'(K3);
            3'd4:    return '0;
            3'd5:    return DATA_W'(-K3);
            3'd6:    return DATA_W'(-K2);
            default: return DATA_W'(-K1);
        endcase
    endfunction

    function automatic logic signed [DATA_W-1:0] sin_lut(input logic [2:0] e);
        case (e)
            3'd0:    return '0;
            3'd1:    return DATA_W'(K3);
            3'd2:    return DATA_W'(K2);
            3'd3:    return DATA_W'(K1);
            3'd4:    return DATA_W'(K0);
            3'd5:    return DATA_W'(K1);
            3'd6:    return DATA_W'(K2);
            default: return DATA_W'(K3);
        endcase
    endfunction

    // e = (j & (2^s - 1)) << (3 - s)
    function automatic logic [2:0] exponent(input logic [1:0] s, input logic [2:0] j);
        case (s)
            2'd0:    return 3'd0;
            2'd1:    return {j[0], 2'b00};
            2'd2:    return {j[1:0], 1'b0};
            default: return j;
        endcase
    endfunction

    state_t                   state;
    logic [4:0]               load_idx;
    logic [2:0]               load_e;
    logic                     load_inv;
    logic signed [DATA_W-1:0] load_re;
    logic signed [DATA_W-1:0] load_sin;

`ifdef TWIDDLE_INVERSE_EN
    logic inv_q;
`endif

    // The next W is prepared from registered state only, so w_ready never
    // reaches an output combinationally.
    always_comb begin
        // NOTE: every always_comb output is given a value on every path, so no latch is inferred.
        load_idx = (state == IDLE) ? 5'd0 : {w.stage, w.bfly} + 5'd1;
        load_e   = exponent(load_idx[4:3], load_idx[2:0]);
        load_re  = cos_lut(load_e);
        load_sin = sin_lut(load_e);
`ifdef TWIDDLE_INVERSE_EN
        load_inv = (state == IDLE) ? inverse : inv_q;
`else
        load_inv = 1'b0;
`endif
    end

    // NOTE: state and outputs use non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            w.w_valid <= 1'b0;
            w.w_re    <= '0;
            w.w_im    <= '0;
            w.stage   <= '0;
            w.bfly    <= '0;
            w.last    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef TWIDDLE_INVERSE_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state              <= RUN;
                        busy               <= 1'b1;
                        w.w_valid          <= 1'b1;
                        w.w_re             <= load_re;
                        w.w_im             <= load_inv ? load_sin : -load_sin;
                        {w.stage, w.bfly}  <= load_idx;
                        w.last             <= 1'b0;
`ifdef TWIDDLE_INVERSE_EN
                        inv_q              <= inverse;
`endif
                    end
                end
                RUN: begin
                    if (w.w_valid && w.w_ready) begin
                        if (w.last) begin
                            state     <= DONE;
                            w.w_valid <= 1'b0;
                            w.last    <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            w.w_re            <= load_re;
                            w.w_im            <= load_inv ? load_sin : -load_sin;
                            {w.stage, w.bfly} <= load_idx;
                            w.last            <= (load_idx == 5'd31);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/twiddle_sequencer.md
# twiddle_sequencer

- Supplies the twiddle factor W (Q2.14, 16-bit signed) that the butterfly's `signed_multiplier` multiplies against Q8.8 data.
- On each `start` pulse, streams the 32 twiddles of one 16-point radix-2 DIT FFT frame: 4 stages × 8 butterflies, in stage-major, butterfly-minor order.
- Output uses a valid/ready handshake so the butterfly datapath can stall it.
- Sits upstream of the butterfly, between the FFT control FSM and the multiplier's `W` input.

## Interface

- `DATA_W`, 16: width of `w_re`/`w_im`; must be ≥ `FRAC_W`+2.
- `FRAC_W`, 14: fractional bits of W; ROM constants = round(value × 2^FRAC_W).

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  frame request; sampled only in IDLE.
- `w_ready`  in  1  consumer accepts current W.
- `w_valid`  out  1  `w_re`/`w_im`/`stage`/`bfly`/`last` are valid.
- `w_re`  out  DATA_W  signed cos(2πe/16).
- `w_im`  out  DATA_W  signed −sin(2πe/16); +sin in inverse mode.
- `stage`  out  2  FFT stage 0..3 of current W.
- `bfly`  out  3  butterfly index j, 0..7, within the stage.
- `last`  out  1  high with the final W of the frame (stage 3, bfly 7).
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse after the last transfer.

## Operation

- Exponent: e = (j & (2^s − 1)) << (3 − s), for stage s and butterfly j.
  - Stage 0: e = 0 for all j.
  - Stage 1: e ∈ {0, 4}.
  - Stage 2: e ∈ {0, 2, 4, 6}.
  - Stage 3: e = j.
- ROM at defaults, indexed e = 0..7:
  - cos: 16384, 15137, 11585, 6270, 0, −6270, −11585, −15137.
  - sin: 0, 6270, 11585, 15137, 16384, 15137, 11585, 6270.
  - 1.0 = 16384 (0x4000) is representable in Q2.14 and is emitted as-is.
- Internal 5-bit counter {stage, bfly}; advances only on a transfer (`w_valid && w_ready`).
- FSM states and transitions:
  - IDLE → RUN when `start` = 1; counter cleared to 0.
  - RUN → RUN on a transfer with `last` = 0; counter +1.
  - RUN → DONE on a transfer with `last` = 1.
  - DONE → IDLE unconditionally after one cycle.
- `start` in RUN or DONE is ignored; it is not queued.
- All outputs are registered; no combinational path from `w_ready` to any output.

## Timing

- Reset values: `w_valid` 0, `w_re` 0, `w_im` 0, `stage` 0, `bfly` 0, `last` 0, `busy` 0, `done` 0; FSM in IDLE.
- `start` high in cycle t (IDLE) → `w_valid` = 1 with stage 0 / bfly 0 in cycle t+1; `busy` = 1 from t+1.
- With `w_ready` held high: one W per cycle, 32 consecutive beats, cycles t+1..t+32.
- Backpressure: while `w_valid` && !`w_ready`, all outputs hold unchanged.
- Throughput: a new W is presented in the cycle after each transfer.
- After the last transfer in cycle n:
  - cycle n+1: `w_valid` = 0, `last` = 0, `done` = 1, `busy` = 1.
  - cycle n+2: IDLE, `busy` = 0; `start` is accepted again from this cycle.
  - Minimum gap between frames: 2 cycles.
- `rst` mid-frame takes priority over every event:
  - all outputs go to reset values at the next edge;
  - the partial frame is abandoned;
  - no `done` pulse is issued.
- `rst` and `start` in the same cycle: reset wins; `start` is lost.

## Configuration

- `TWIDDLE_INVERSE_EN` defined:
  - adds input `inverse` (1 bit), sampled together with an accepted `start`;
  - the sampled value is held for the whole frame;
  - when set, `w_im` = +sin(2πe/16) (conjugate twiddles, IFFT);
  - `w_re` is unchanged.
- `TWIDDLE_INVERSE_EN` undefined: the `inverse` port does not exist; forward twiddles only.

## Test plan

- Reset, then idle 5 cycles → all outputs at reset values; `busy` = 0.
- `start` pulse, `w_ready` = 1 → 32 beats on consecutive cycles:
  - stage 0: all (16384, 0);
  - stage 2, bfly 1: (11585, −11585);
  - stage 3, bfly 3: (6270, −15137);
  - `last` only on beat 32;
  - `done` 1 cycle after beat 32, `busy` = 0 one cycle after that.
- Backpressure: drop `w_ready` for 4 cycles at stage 1 / bfly 1 → outputs held at (0, −16384); sequence resumes with bfly 2; still exactly 32 transfers.
- `start` re-pulsed during RUN and during DONE → ignored; single frame, single `done`.
- `rst` asserted at stage 2 / bfly 5 → outputs at reset values next cycle, no `done`; a fresh `start` restarts from stage 0 / bfly 0.
- `TWIDDLE_INVERSE_EN`, `inverse` = 1 with `start` → stage 3, bfly 2 yields (11585, +11585).
